// File: rtl/dist_ram_rd_arbiter_pkg.sv
// Shared definitions for the lookup-table read arbiter: FSM encoding, default sizes, log2 helper.
package dist_ram_rd_arbiter_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int BRAM_DEPTH_DEF = 64;
  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Ceiling log2; callers only pass powers of two, so this is exact.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/dist_ram_rd_arbiter_if.sv
// Client lookup, response and host-write bundle; master = clients/host side, slave = arbiter.
interface dist_ram_rd_arbiter_if
  import dist_ram_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ADDR_WIDTH = log2(BRAM_DEPTH_DEF),
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = log2(NUM_REQ_DEF)
);

  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_rdy;
  logic                          rsp_vld;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          wr_vld;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          wr_rdy;
  logic                          init_done;

  modport master (
    output req_vld, req_addr, wr_vld, wr_addr, wr_data,
    input  req_rdy, rsp_vld, rsp_id, rsp_data, wr_rdy, init_done
  );

  modport slave (
    input  req_vld, req_addr, wr_vld, wr_addr, wr_data,
    output req_rdy, rsp_vld, rsp_id, rsp_data, wr_rdy, init_done
  );

endinterface

// File: rtl/dist_ram_rd_arbiter_sdport.sv
// Simple-dual-port distributed RAM: synchronous write on a/d/we, read port dpra with registered qdpo.
// Read of an address being written the same cycle returns the old entry (read-before-write).
module XDistRamSDPort #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [ADDR_WIDTH-1:0] dpra,
  output logic [DATA_WIDTH-1:0] qdpo
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[a] <= d;
    qdpo <= mem_q[dpra];
  end

endmodule

// File: rtl/dist_ram_rd_arbiter.sv
// Round-robin read arbiter + zero-fill/host-write owner of a shared SDP lookup table; 1-cycle lookup latency.
// Optional write-to-read bypass on same-address collision: DIST_RAM_RD_ARB_WR_BYPASS_EN.
module dist_ram_rd_arbiter
  import dist_ram_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int BRAM_DEPTH = BRAM_DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = log2(BRAM_DEPTH),
  parameter int ID_WIDTH   = log2(NUM_REQ)
) (
  input logic                  clk,
  input logic                  rst,
  dist_ram_rd_arbiter_if.slave arb
);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  rsp_vld_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;

  logic                  run;
  logic                  init_phase;
  logic                  gnt_any;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [ID_WIDTH-1:0]   scan_idx;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  wr_fire;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] rsp_dat;

  // rst gates the handshakes combinationally so no grant or write slips through a reset cycle
  assign run        = (state_q == S_RUN) && !rst;
  assign init_phase = (state_q == S_INIT);

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = rr_ptr_q + ID_WIDTH'(k);
      if (!gnt_any && arb.req_vld[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    gnt_any = gnt_any && run;
  end

  assign gnt_addr    = arb.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign arb.req_rdy = gnt_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign wr_fire     = run && arb.wr_vld;
  assign arb.wr_rdy  = run;

  assign ram_we = init_phase || wr_fire;
  assign ram_a  = init_phase ? fill_q : arb.wr_addr;
  assign ram_d  = init_phase ? '0 : arb.wr_data;

  XDistRamSDPort #(
    .DEPTH      (BRAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .a    (ram_a),
    .d    (ram_d),
    .dpra (gnt_addr),
    .qdpo (ram_q)
  );

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    rr_ptr_d = rr_ptr_q;
    if (init_phase) begin
      fill_d = fill_q + ADDR_WIDTH'(1);
      if (fill_q == ADDR_WIDTH'(BRAM_DEPTH - 1)) state_d = S_RUN;
    end
    if (gnt_any) rr_ptr_d = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      fill_q    <= '0;
      rr_ptr_q  <= ID_WIDTH'(NUM_REQ - 1);
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_vld_q <= gnt_any;
      if (gnt_any) rsp_id_q <= gnt_idx;
    end
  end

`ifdef DIST_RAM_RD_ARB_WR_BYPASS_EN
  logic                  byp_hit_q;
  logic [DATA_WIDTH-1:0] byp_dat_q;

  // Capture the colliding write so the read returns the new value instead of the RAM's old entry
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit_q <= 1'b0;
      byp_dat_q <= '0;
    end else begin
      byp_hit_q <= gnt_any && wr_fire && (arb.wr_addr == gnt_addr);
      byp_dat_q <= arb.wr_data;
    end
  end

  assign rsp_dat = byp_hit_q ? byp_dat_q : ram_q;
`else
  assign rsp_dat = ram_q;
`endif

  assign arb.rsp_vld   = rsp_vld_q && !rst;
  assign arb.rsp_id    = rst ? '0 : rsp_id_q;
  assign arb.rsp_data  = arb.rsp_vld ? rsp_dat : '0;
  assign arb.init_done = run;

endmodule

// File: tb/tb_dist_ram_rd_arbiter.sv
// Bench for dist_ram_rd_arbiter: vector table for grants, scoreboard queue for responses, scripted reset cases.
module tb_dist_ram_rd_arbiter;

  localparam int NR    = 4;
  localparam int DEPTH = 64;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int IW    = 2;
  localparam int NVEC  = 18;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [NR-1:0]    vld;
    logic [NR*AW-1:0] addr;
    logic             wv;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [NR-1:0]    rdy;
  } vec_t;

  logic clk;
  logic rst;

  dist_ram_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  dist_ram_rd_arbiter #(
    .NUM_REQ    (NR),
    .BRAM_DEPTH (DEPTH),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ID_WIDTH   (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  exp_t sb_q[$];
  logic [DW-1:0] model [DEPTH];
  vec_t tbl [NVEC];

  // client addresses: c0=5, c1=63, c2=3, c3=10; collision variant puts c0 on 7
  localparam logic [NR*AW-1:0] A_DEF = {6'd10, 6'd3, 6'd63, 6'd5};
  localparam logic [NR*AW-1:0] A_COL = {6'd10, 6'd3, 6'd63, 6'd7};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Called at posedge+1 with inputs already driven; returns at posedge+1 of the next cycle.
  task automatic cycle(input logic [NR-1:0] exp_rdy, input logic exp_init);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          wfire;
    exp_t          e;
    #3;
    check("req_rdy", bus.req_rdy, exp_rdy);
    check("wr_rdy", bus.wr_rdy, exp_init);
    check("init_done", bus.init_done, exp_init);
    wfire = bus.wr_vld && exp_init;
    for (int i = 0; i < NR; i++) begin
      if (exp_rdy[i]) begin
        a = bus.req_addr[i*AW +: AW];
        d = model[a];
`ifdef DIST_RAM_RD_ARB_WR_BYPASS_EN
        if (wfire && bus.wr_addr == a) d = bus.wr_data;
`endif
        sb_q.push_back('{id: IW'(i), data: d});
      end
    end
    @(posedge clk);
    if (wfire) model[bus.wr_addr] = bus.wr_data;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_vld", bus.rsp_vld, 1'b1);
      check("rsp_id", bus.rsp_id, e.id);
      check("rsp_data", bus.rsp_data, e.data);
    end else begin
      check("rsp_vld_idle", bus.rsp_vld, 1'b0);
      check("rsp_data_idle", bus.rsp_data, '0);
    end
  endtask

  // Releases reset and runs the zero-fill with clients and host hammering; nothing may be accepted.
  task automatic run_init();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    sb_q.delete();
    bus.req_vld  = '1;
    bus.req_addr = A_DEF;
    bus.wr_vld   = 1'b1;
    bus.wr_addr  = 6'd5;
    bus.wr_data  = 32'hBAD0_BAD0;
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) cycle('0, 1'b0);
    bus.req_vld = '0;
    bus.wr_vld  = 1'b0;
    check("init_done_rise", bus.init_done, 1'b1);
    check("wr_rdy_rise", bus.wr_rdy, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{4'b1111, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0001};
    tbl[1]  = '{4'b0000, A_DEF, 1'b1, 6'd3,  32'hA5A5_0003, 4'b0000};
    tbl[2]  = '{4'b0100, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0100};
    tbl[3]  = '{4'b0000, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0000};
    tbl[4]  = '{4'b1111, A_DEF, 1'b0, 6'd0,  32'h0,         4'b1000};
    tbl[5]  = '{4'b1111, A_DEF, 1'b1, 6'd10, 32'hDEAD_0010, 4'b0001};
    tbl[6]  = '{4'b1111, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0010};
    tbl[7]  = '{4'b1111, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0100};
    tbl[8]  = '{4'b1111, A_DEF, 1'b0, 6'd0,  32'h0,         4'b1000};
    tbl[9]  = '{4'b1111, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0001};
    tbl[10] = '{4'b1010, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0010};
    tbl[11] = '{4'b1010, A_DEF, 1'b0, 6'd0,  32'h0,         4'b1000};
    tbl[12] = '{4'b1010, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0010};
    tbl[13] = '{4'b1010, A_DEF, 1'b0, 6'd0,  32'h0,         4'b1000};
    tbl[14] = '{4'b0000, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0000};
    tbl[15] = '{4'b0001, A_COL, 1'b1, 6'd7,  32'h1234_5678, 4'b0001};
    tbl[16] = '{4'b0001, A_COL, 1'b0, 6'd0,  32'h0,         4'b0001};
    tbl[17] = '{4'b0000, A_DEF, 1'b0, 6'd0,  32'h0,         4'b0000};

    rst          = 1'b1;
    bus.req_vld  = '1;
    bus.req_addr = A_DEF;
    bus.wr_vld   = 1'b1;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy", bus.req_rdy, '0);
    check("rst_rsp_vld", bus.rsp_vld, 1'b0);
    check("rst_rsp_id", bus.rsp_id, '0);
    check("rst_rsp_data", bus.rsp_data, '0);
    check("rst_wr_rdy", bus.wr_rdy, 1'b0);
    check("rst_init_done", bus.init_done, 1'b0);

    run_init();

    for (int v = 0; v < NVEC; v++) begin
      bus.req_vld  = tbl[v].vld;
      bus.req_addr = tbl[v].addr;
      bus.wr_vld   = tbl[v].wv;
      bus.wr_addr  = tbl[v].wa;
      bus.wr_data  = tbl[v].wd;
      cycle(tbl[v].rdy, 1'b1);
    end

    // Reset lands the cycle after a grant: the pending response must never show
    bus.req_vld  = 4'b0001;
    bus.req_addr = A_DEF;
    bus.wr_vld   = 1'b0;
    #3;
    check("pre_rst_grant", bus.req_rdy, 4'b0001);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_vld = '0;
    #3;
    check("rst_drop_vld", bus.rsp_vld, 1'b0);
    check("rst_drop_data", bus.rsp_data, '0);
    @(posedge clk);
    #1;
    check("rst_after_vld", bus.rsp_vld, 1'b0);
    check("rst_after_init", bus.init_done, 1'b0);

    run_init();

    // Address 3 held 0xA5A50003 before the reset; refill must have cleared it
    bus.req_vld = 4'b0100;
    cycle(4'b0100, 1'b1);
    bus.req_vld = '0;
    cycle('0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dist_ram_rd_arbiter.md
# dist_ram_rd_arbiter

Round-robin read arbiter and initialiser for a shared simple-dual-port distributed-RAM lookup table. It owns the table's single write port, used first for post-reset zero-fill and then for host updates, and its single read port, time-shared between NUM_REQ lookup clients. It sits between the per-port lookup engines and the table, returning one tagged response per granted lookup.

## Interface
- NUM_REQ, 4: number of lookup clients; power of two, 2..8
- BRAM_DEPTH, 64: table entries; power of two
- DATA_WIDTH, 32: entry width
- ADDR_WIDTH, log2(BRAM_DEPTH): table address width
- ID_WIDTH, log2(NUM_REQ): response tag width
- clk  in  1  sole clock
- rst  in  1  reset, synchronous, active-high
- req_vld  in  NUM_REQ  per-client lookup request
- req_addr  in  NUM_REQ*ADDR_WIDTH  client i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_rdy  out  NUM_REQ  one-hot grant; a request is accepted when req_vld[i] & req_rdy[i]
- rsp_vld  out  1  lookup result valid, one cycle per accepted request
- rsp_id  out  ID_WIDTH  index of the client the result belongs to
- rsp_data  out  DATA_WIDTH  table entry; forced to 0 when rsp_vld=0
- wr_vld  in  1  host write request
- wr_addr  in  ADDR_WIDTH  host write address
- wr_data  in  DATA_WIDTH  host write data
- wr_rdy  out  1  host write accepted when wr_vld & wr_rdy
- init_done  out  1  zero-fill complete, table in service

## Operation
- FSM states: S_INIT, S_RUN. Reset enters S_INIT with fill counter = 0.
- S_INIT: each cycle writes 0 to address fill counter, then increments it. After address BRAM_DEPTH-1 is written, the FSM moves to S_RUN. req_rdy=0, wr_rdy=0, init_done=0.
- S_RUN: init_done=1 and wr_rdy=1 permanently. Host writes go straight to the write port. Writes have no conflict with reads.
- Arbitration, S_RUN only: rr_ptr holds the last granted index. The grant goes to the first i with req_vld[i]=1, searching from rr_ptr+1 modulo NUM_REQ. At most one req_rdy bit is set per cycle.
- req_rdy depends combinationally on req_vld. It is never asserted for a client whose req_vld=0.
- rr_ptr updates to the granted index only on a grant. Reset value is NUM_REQ-1, so client 0 has first priority.
- The granted address drives the read port the same cycle.
- The grant index is registered into rsp_id, alongside a valid bit that becomes rsp_vld.
- Read/write collision, where an accepted host write and a granted read use the same address in the same cycle: see Configuration.
- Reset mid-operation: any in-flight response is dropped (rsp_vld=0 next cycle), rr_ptr reloads, and the zero-fill restarts from address 0.

## Timing
- Reset values: req_rdy=0, rsp_vld=0, rsp_id=0, rsp_data=0, wr_rdy=0, init_done=0.
- Zero-fill takes exactly BRAM_DEPTH cycles after rst deasserts. init_done rises on cycle BRAM_DEPTH (cycles counted from 0 at the first cycle with rst=0).
- Lookup latency: a grant in cycle N gives rsp_vld=1 in cycle N+1, with the RAM's registered read data.
- Sustained throughput: one lookup per cycle aggregate. With all clients requesting, each client is granted once every NUM_REQ cycles.
- A write accepted in cycle N is visible to reads granted in cycle N+1 or later.

## Configuration
- Macro DIST_RAM_RD_ARB_WR_BYPASS_EN.
- Defined: on a same-cycle same-address collision, the write data is registered and returned as rsp_data in cycle N+1, so the read sees the new value.
- Undefined: rsp_data returns the old entry (read-before-write), and the bypass register and comparator are not built.

## Structure
- Shared package: state encoding (S_INIT, S_RUN), log2 function, and the default widths NUM_REQ/BRAM_DEPTH/DATA_WIDTH.
- One sub-module: the existing XDistRamSDPort.
  - a/d/we are driven by a mux of the fill counter and the host write.
  - dpra is driven by the grant address mux.
  - qdpo feeds rsp_data.
- Round-robin grant logic stays inline.

## Test plan
- Reset release, NUM_REQ=4, BRAM_DEPTH=64: init_done rises after exactly 64 cycles; req_rdy and wr_rdy stay 0 before that. A read of any address afterwards returns 0.
- Host writes 0xA5A5_0003 to address 3, then client 2 reads address 3: the grant is on req_rdy[2], and the next cycle gives rsp_vld=1, rsp_id=2, rsp_data=0xA5A5_0003.
- All four clients request continuously, each at a distinct address: grants follow the order 0,1,2,3,0,…. Responses are back-to-back with matching rsp_id and data.
- Only clients 1 and 3 request, with rr_ptr=1: client 3 is granted, then client 1, alternating.
- In the same cycle, a host write of 0x1234_5678 to address 7 and a client 0 read of address 7 (old value 0): the response is 0x1234_5678 with the macro defined and 0 without it.
- rst asserted the cycle after a grant: rsp_vld stays 0, and the zero-fill restarts (init_done=0 for the next 64 cycles).
